// File: rtl/button_debouncer.sv
// Two-FF synchronizer plus counter-qualified debounce FSM for a push button.
// Level change and pulse appear 2+STABLE_CYCLES edges after a clean pin edge; no backpressure.
module button_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 20,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       button_pin,
  output logic       button_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 sync1, sync2;
  logic                 level_nxt, press_nxt, release_nxt;
  logic [7:0]           count_nxt;
  logic                 sample;

  // Normalise polarity so that 1 always means pressed downstream.
  assign sample = button_pin ^ (ACTIVE_LOW != 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sample;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      button_level  <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      press_count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = button_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    count_nxt   = press_count;
    case (state)
      RELEASED: begin
        if (sync2) begin
          state_nxt = CONFIRM_PRESS;
          cnt_nxt   = CNT_WIDTH'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      CONFIRM_PRESS: begin
        // A single released sample is a bounce and restarts qualification.
        if (!sync2) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          count_nxt = press_count + 8'd1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_nxt = CONFIRM_RELEASE;
          cnt_nxt   = CNT_WIDTH'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      CONFIRM_RELEASE: begin
        if (sync2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt   = RELEASED;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: each task pushes the pulses its stimulus must produce; a monitor pops and checks them.
module tb_button_debouncer;

  localparam int SC = 4;
  localparam int LAT = 2 + SC;

  typedef struct {
    int   cyc;
    logic is_press;
    int   count;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       button_pin = 1'b1;
  logic       button_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  n_press = 0;
  int  n_release = 0;
  int  exp_count = 0;
  ev_t sb[$];

  button_debouncer #(.STABLE_CYCLES(SC), .CNT_WIDTH(3), .ACTIVE_LOW(1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .button_pin(button_pin),
    .button_level(button_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    ev_t e;
    #1;
    if (press_pulse) n_press++;
    if (release_pulse) n_release++;
    if (press_pulse && release_pulse) begin
      total++; bad++;
      $display("FAIL both_pulses cyc=%0d press=1 release=1 required one at most", cyc);
    end
    if (press_pulse || release_pulse) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d press=%0b release=%0b required none", cyc, press_pulse, release_pulse);
      end else begin
        e = sb.pop_front();
        if (e.cyc !== cyc || e.is_press !== press_pulse || e.count !== int'(press_count) ||
            button_level !== press_pulse) begin
          bad++;
          $display("FAIL pulse_event got cyc=%0d press=%0b count=%0d level=%0b required cyc=%0d press=%0b count=%0d",
                   cyc, press_pulse, press_count, button_level, e.cyc, e.is_press, e.count);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input logic is_press);
    ev_t e;
    if (is_press) exp_count = (exp_count + 1) % 256;
    e.cyc = cyc + LAT;
    e.is_press = is_press;
    e.count = exp_count;
    sb.push_back(e);
  endtask

  task automatic check_idle(input string name, input logic lvl);
    total++;
    if (sb.size() != 0 || button_level !== lvl || int'(press_count) !== exp_count) begin
      bad++;
      $display("FAIL %s pending=%0d level=%0b count=%0d required pending=0 level=%0b count=%0d",
               name, sb.size(), button_level, press_count, lvl, exp_count);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    exp_count = 0;
    repeat (n) begin
      @(negedge clk);
      total++;
      if ({button_level, press_pulse, release_pulse, press_count} !== 11'd0) begin
        bad++;
        $display("FAIL in_reset outputs=%b required all zero",
                 {button_level, press_pulse, release_pulse, press_count});
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    button_pin = 1'b1;
    do_reset(3);
    repeat (20) begin
      @(negedge clk);
      total++;
      if ({button_level, press_pulse, release_pulse, press_count} !== 11'd0) begin
        bad++;
        $display("FAIL idle outputs=%b required all zero",
                 {button_level, press_pulse, release_pulse, press_count});
      end
    end
  endtask

  task automatic test_press;
    button_pin = 1'b0;
    push_ev(1'b1);
    tick(LAT + 3);
    check_idle("press_done", 1'b1);
  endtask

  task automatic test_release;
    button_pin = 1'b1;
    push_ev(1'b0);
    tick(LAT + 3);
    check_idle("release_done", 1'b0);
  endtask

  task automatic test_bounce;
    button_pin = 1'b0; tick(3);
    button_pin = 1'b1; tick(1);
    button_pin = 1'b0; tick(3);
    button_pin = 1'b1; tick(8);
    check_idle("bounce_rejected", 1'b0);
    test_press();
    test_release();
  endtask

  task automatic test_wrap;
    int p0, r0;
    do_reset(2);
    tick(4);
    p0 = n_press;
    r0 = n_release;
    for (int i = 1; i <= 256; i++) begin
      test_press();
      test_release();
      if (i == 255) begin
        total++;
        if (press_count !== 8'd255) begin
          bad++;
          $display("FAIL wrap_255 count=%0d required 255", press_count);
        end
      end
    end
    total++;
    if (press_count !== 8'd0 || n_press - p0 != 256 || n_release - r0 != 256) begin
      bad++;
      $display("FAIL wrap_256 count=%0d presses=%0d releases=%0d required 0/256/256",
               press_count, n_press - p0, n_release - r0);
    end
  endtask

  task automatic test_reset_mid;
    ev_t e;
    button_pin = 1'b0;
    tick(2);
    reset_n = 1'b0;
    exp_count = 0;
    tick(2);
    total++;
    if ({button_level, press_pulse, press_count} !== 10'd0) begin
      bad++;
      $display("FAIL mid_reset outputs=%b required all zero", {button_level, press_pulse, press_count});
    end
    reset_n = 1'b1;
    push_ev(1'b1);
    tick(LAT + 3);
    check_idle("reset_mid_press", 1'b1);
    test_release();
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_wrap();
    test_reset_mid();
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Sits directly upstream of the 1-bit button PIO input port. Takes a raw, asynchronous, bouncy push-button pin and drives the PIO `in_port` with a clean, synchronized level.
- Synchronizes the pin with a 2-FF chain, then debounces it with a counter-qualified state machine.
- Also provides one-cycle press/release pulses and a wrapping press counter for local logic and debug.

Parameters:
- STABLE_CYCLES, 500000, consecutive synchronized cycles a new level must hold before acceptance (10 ms at 50 MHz); legal range >= 2.
- CNT_WIDTH, 20, debounce counter width; must satisfy 2^CNT_WIDTH > STABLE_CYCLES-1.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- button_pin  input  1  raw pin from board, asynchronous to clk
- button_level  output  1  debounced level, 1 = pressed (drives PIO in_port)
- press_pulse  output  1  one-cycle high on accepted press
- release_pulse  output  1  one-cycle high on accepted release
- press_count  output  8  accepted presses, modulo 256

Behaviour:
- Polarity: sample = button_pin XOR ACTIVE_LOW, so 1 = pressed internally.
- Sync: sync1 <= sample; sync2 <= sync1. On reset both clear to 0, the released level. The rest of the logic reads only sync2.
- Reset values: button_level 0, press_pulse 0, release_pulse 0, press_count 0, counter 0, state RELEASED.
- States: RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
- RELEASED:
  - sync2=1 -> CONFIRM_PRESS, counter <= 1.
  - Otherwise stay, counter 0.
- CONFIRM_PRESS:
  - sync2=0 -> RELEASED, counter <= 0. This is a bounce: no outputs change.
  - sync2=1 and counter == STABLE_CYCLES-1 -> PRESSED, counter <= 0, button_level <= 1, press_pulse <= 1, press_count <= press_count+1.
  - sync2=1 otherwise -> counter++.
- PRESSED and CONFIRM_RELEASE mirror the above with sync2 inverted. On acceptance: button_level <= 0, release_pulse <= 1, press_count unchanged.
- A level is accepted on the STABLE_CYCLES-th consecutive cycle in which sync2 differs from button_level. Any single disagreeing cycle restarts qualification from zero.
- Latency: a clean pin edge produces a button_level change and pulse exactly 2+STABLE_CYCLES rising edges later.
- Pulses:
  - Registered. Each is high for exactly one cycle and is 0 on every other cycle.
  - press_pulse and release_pulse are never high together.
  - Back-to-back pulses are impossible; at least STABLE_CYCLES cycles separate them.
- press_count wraps 255 -> 0 with no flag.
- All outputs are registered; no combinational path from button_pin.
- Reset mid-qualification (reset_n low at any time): all state returns to reset values immediately. No pulse is emitted and the partial count is discarded.
- Button held pressed through reset: after reset_n deasserts it is treated as a new press. press_pulse fires after 2+STABLE_CYCLES cycles and press_count becomes 1.
- Counter never exceeds STABLE_CYCLES-1; no overflow path.

Test Plan (STABLE_CYCLES=4, ACTIVE_LOW=1, pin idles 1):
- Reset/idle: reset_n low 3 cycles with pin=1, then release and run 20 cycles -> all outputs 0 throughout, no pulses.
- Clean press: pin 1->0 before edge E and held -> button_level rises and press_pulse is high for one cycle at edge E+5, press_count=1; no other pulses.
- Bounce rejection: pin 0 for 3 cycles, 1 for 1, 0 for 3, then 1 -> button_level stays 0, no pulse, press_count 0. Then pin 0 held 4+ cycles -> accepted at change+6 edges.
- Release: from pressed, pin 0->1 held -> button_level falls and release_pulse is high for one cycle 6 edges after the change; press_count unchanged.
- Wrap: 256 clean press/release pairs -> press_count reads 255 after pair 255 and 0 after pair 256, with exactly 256 press_pulse and 256 release_pulse events.
- Reset mid-operation: pin 0 held, assert reset_n low 2 cycles after the change (inside qualification) for 2 cycles, then release with pin still 0 -> no pulse during or just after reset. Then press_pulse and button_level=1 at 6 edges after reset deassertion, press_count=1.
